// File: rtl/tt_um_sequencer.sv
// Job sequencer for a weight-load / MAC / row-drain array: loads 2*(R+1) weight halves,
// clears and steps the MAC through C+1 activation columns, then presents R+1 result rows.
module tt_um_sequencer #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    localparam int CW = $clog2(MAX_IN_LEN),
    localparam int RW = $clog2(MAX_OUT_LEN),
    localparam int BW = RW + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             ui_start,
    input  logic [RW+CW-1:0] ui_param,
    input  logic             ui_in_valid,
    input  logic             ui_out_ready,
    input  logic             load_done,
    output logic             load_ena,
    output logic             mac_clear,
    output logic             mac_ena,
    output logic [CW-1:0]    col_idx,
    output logic             out_valid,
    output logic [RW-1:0]    out_row,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t        state, state_next;
    logic [RW-1:0] r_lat, rc;
    logic [CW-1:0] c_lat, cc;
    logic [BW-1:0] bc;
    logic          first;
    logic          err_q, done_q;
    logic          accept;
    logic          last_row;

    assign accept   = ena & ui_in_valid;
    assign last_row = (state == DRAIN) && ui_out_ready && (rc == r_lat);
    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign err      = err_q;

    always_comb begin
        state_next = state;
        load_ena   = 1'b0;
        mac_clear  = 1'b0;
        mac_ena    = 1'b0;
        col_idx    = '0;
        out_valid  = 1'b0;
        out_row    = '0;
        case (state)
            IDLE: begin
                if (ena && ui_start) state_next = LOAD;
            end
            LOAD: begin
                load_ena = accept;
                if (accept && bc == {1'b0, r_lat, 1'b1}) state_next = COMPUTE;
            end
            COMPUTE: begin
                col_idx = cc;
                // The first COMPUTE cycle only clears the accumulators; no column is consumed.
                if (first) begin
                    mac_clear = ena;
                end else begin
                    mac_ena = accept;
                    if (accept && cc == c_lat) state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_row   = rc;
                if (ena && last_row) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            r_lat  <= '0;
            c_lat  <= '0;
            bc     <= '0;
            cc     <= '0;
            rc     <= '0;
            first  <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= ena && last_row;
            if (ena) begin
                state <= state_next;
                case (state)
                    IDLE: begin
                        if (ui_start) begin
                            r_lat <= ui_param[RW-1:0];
                            c_lat <= ui_param[RW+:CW];
                            bc    <= '0;
                            cc    <= '0;
                            rc    <= '0;
                            first <= 1'b1;
                            err_q <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (ui_in_valid) begin
                            bc <= bc + 1'b1;
                            // Even beats are row MSBs; load_done must mark exactly the last row's MSB.
                            if (!bc[0] && (load_done != (bc == {1'b0, r_lat, 1'b0}))) err_q <= 1'b1;
                        end
                    end
                    COMPUTE: begin
                        if (first) first <= 1'b0;
                        else if (ui_in_valid && cc != c_lat) cc <= cc + 1'b1;
                    end
                    DRAIN: begin
                        if (ui_out_ready && rc != r_lat) rc <= rc + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_um_sequencer.sv
// Randomized bench for tt_um_sequencer; a job-level model predicts every output per cycle.
module tb_tt_um_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       ui_start = 1'b0;
    logic [6:0] ui_param = '0;
    logic       ui_in_valid = 1'b0;
    logic       ui_out_ready = 1'b0;
    logic       load_done = 1'b0;
    logic       load_ena, mac_clear, mac_ena, out_valid, busy, done, err;
    logic [3:0] col_idx;
    logic [2:0] out_row;

    int n_chk = 0;
    int n_fail = 0;

    tt_um_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_start(ui_start), .ui_param(ui_param),
        .ui_in_valid(ui_in_valid), .ui_out_ready(ui_out_ready), .load_done(load_done),
        .load_ena(load_ena), .mac_clear(mac_clear), .mac_ena(mac_ena), .col_idx(col_idx),
        .out_valid(out_valid), .out_row(out_row), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Issue a start from IDLE with the given geometry.
    task automatic start_job(input int r, input int c);
        @(negedge clk);
        ena = 1'b1;
        ui_start = 1'b1;
        ui_param = 7'(c * 8 + r);
        ui_in_valid = 1'b1;
        #1;
        n_chk++;
        if (busy !== 1'b0 || load_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL start_idle: busy=%b load_ena=%b, required 0 0", busy, load_ena);
        end
    endtask

    // Runs one job from the first cycle after the start edge through the done cycle.
    // ld_mode: 0 = load_done on the last row MSB, 1 = random, 2 = only on beat bad_beat.
    // next_p >= 0 issues a new start in the done cycle with that ui_param.
    task automatic run_body(input int r, input int c, input int ena_pct, input int vld_pct,
                            input int rdy_pct, input int ld_mode, input int bad_beat,
                            input int next_p);
        int beats = 0, macs = 0, rows = 0, cyc = 0;
        bit cleared = 0, err_m = 0, fin = 0;
        bit in_load, in_clear, in_comp, in_drain;
        while (!fin) begin
            @(negedge clk);
            in_load  = beats < 2 * r + 2;
            in_clear = !in_load && !cleared;
            in_comp  = !in_load && cleared && macs <= c;
            in_drain = !in_load && cleared && macs > c;
            ena          = in_drain ? 1'b1 : ($urandom_range(0, 99) < ena_pct);
            ui_in_valid  = $urandom_range(0, 99) < vld_pct;
            ui_out_ready = $urandom_range(0, 99) < rdy_pct;
            ui_start     = 1'($urandom);
            ui_param     = 7'($urandom);
            case (ld_mode)
                0:       load_done = (beats == 2 * r);
                1:       load_done = 1'($urandom);
                default: load_done = (beats == bad_beat);
            endcase
            #1;
            n_chk++;
            if (busy !== 1'b1 || done !== 1'b0 || err !== err_m) begin
                n_fail++;
                $display("FAIL status: busy=%b done=%b err=%b, required 1 0 %b", busy, done, err, err_m);
            end
            n_chk++;
            if (load_ena !== (in_load & ena & ui_in_valid)) begin
                n_fail++;
                $display("FAIL load_ena: got %b, required %b", load_ena, in_load & ena & ui_in_valid);
            end
            n_chk++;
            if (mac_clear !== (in_clear & ena) || mac_ena !== (in_comp & ena & ui_in_valid)) begin
                n_fail++;
                $display("FAIL mac_ctl: clear=%b ena=%b, required %b %b", mac_clear, mac_ena,
                         in_clear & ena, in_comp & ena & ui_in_valid);
            end
            n_chk++;
            if (col_idx !== 4'((in_load || in_drain) ? 0 : macs)) begin
                n_fail++;
                $display("FAIL col_idx: got %0d, required %0d", col_idx, (in_load || in_drain) ? 0 : macs);
            end
            n_chk++;
            if (out_valid !== in_drain || out_row !== 3'(in_drain ? rows : 0)) begin
                n_fail++;
                $display("FAIL out_row: valid=%b row=%0d, required %b %0d", out_valid, out_row,
                         in_drain, in_drain ? rows : 0);
            end
            if (in_load && ena && ui_in_valid) begin
                if (beats % 2 == 0 && (load_done != (beats == 2 * r))) err_m = 1;
                beats++;
            end else if (in_clear && ena) begin
                cleared = 1;
            end else if (in_comp && ena && ui_in_valid) begin
                macs++;
            end else if (in_drain && ena && ui_out_ready) begin
                rows++;
                if (rows > r) fin = 1;
            end
            cyc++;
            if (cyc > 3000) begin
                n_chk++;
                n_fail++;
                $display("FAIL job_timeout: got no completion in %0d cycles, required completion", cyc);
                fin = 1;
            end
        end
        @(negedge clk);
        ena = 1'b1;
        ui_in_valid = 1'b1;
        ui_start = (next_p >= 0);
        ui_param = 7'(next_p);
        #1;
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== err_m || load_ena !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_cycle: done=%b busy=%b err=%b load_ena=%b out_valid=%b, required 1 0 %b 0 0",
                     done, busy, err, load_ena, out_valid, err_m);
        end
    endtask

    task automatic test_reset;
        #2;
        n_chk++;
        if ({load_ena, mac_clear, mac_ena, col_idx, out_valid, out_row, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {load_ena, mac_clear, mac_ena, col_idx, out_valid, out_row, busy, done, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1;
        ui_in_valid = 1'b1;
        @(negedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || load_ena !== 1'b0 || mac_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b load_ena=%b mac_ena=%b, required 0 0 0", busy, load_ena, mac_ena);
        end
    endtask

    task automatic test_ena_idle;
        @(negedge clk);
        ena = 1'b0;
        ui_start = 1'b1;
        @(negedge clk);
        ui_start = 1'b0;
        ena = 1'b1;
        #1;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ena_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_nominal;
        start_job(1, 3);
        run_body(1, 3, 100, 100, 100, 0, 0, -1);
    endtask

    task automatic test_minimum;
        start_job(0, 0);
        run_body(0, 0, 100, 100, 100, 0, 0, -1);
    endtask

    // Error job followed back-to-back by a clean job started in the done cycle.
    task automatic test_back_to_back;
        start_job(2, 1);
        run_body(2, 1, 100, 100, 100, 2, 2, 2 * 8 + 3);
        run_body(3, 2, 90, 80, 70, 0, 0, -1);
    endtask

    task automatic test_stall;
        for (int i = 0; i < 4; i++) begin
            int r = $urandom_range(0, 7);
            int c = $urandom_range(0, 15);
            start_job(r, c);
            run_body(r, c, 60, 70, 50, 0, 0, -1);
        end
    endtask

    task automatic test_maximum;
        start_job(7, 15);
        run_body(7, 15, 85, 85, 60, 0, 0, -1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            int r = $urandom_range(0, 7);
            int c = $urandom_range(0, 15);
            start_job(r, c);
            run_body(r, c, 80, 75, 60, 1, 0, -1);
        end
    endtask

    task automatic test_reset_mid_load;
        start_job(3, 5);
        @(negedge clk);
        ui_start = 1'b0;
        ui_in_valid = 1'b1;
        load_done = 1'b1;
        #1;
        n_chk++;
        if (load_ena !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_load_ena: got %b, required 1", load_ena);
        end
        @(negedge clk);
        load_done = 1'b0;
        ui_start = 1'b1;
        #1;
        n_chk++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_load_err: err=%b busy=%b, required 1 1", err, busy);
        end
        ui_start = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({load_ena, mac_clear, mac_ena, col_idx, out_valid, out_row, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %b, required all zero",
                     {load_ena, mac_clear, mac_ena, col_idx, out_valid, out_row, busy, done, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_chk++;
            if (busy !== 1'b0 || done !== 1'b0 || load_ena !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle: busy=%b done=%b load_ena=%b, required 0 0 0", busy, done, load_ena);
            end
        end
    endtask

    initial begin
        test_reset;
        test_ena_idle;
        test_nominal;
        test_minimum;
        test_back_to_back;
        test_stall;
        test_maximum;
        test_random;
        test_reset_mid_load;
        test_nominal;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
